// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider and the EX/ctrl handshake around it.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left and try to subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // The compare runs WIDTH+1 wide; once it passes, the difference is below the divisor and fits WIDTH bits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor_i});
    rem_o   = fits ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// WIDTH-cycle radix-2 divider for DIV/DIVU; result_o = {remainder, quotient}.
// Signed operation is only built when DIV_SIGNED_EN is defined; otherwise every divide is unsigned.
module div_unit
  import div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  divState_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     rem_q, quo_q, divisor_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q, divZero_q;
  logic [WIDTH-1:0]     stepRem, stepQuo, finalRem, finalQuo;
  logic [WIDTH-1:0]     dividendMag, divisorMag;
  logic                 accept, divByZero, lastStep;

  assign accept    = (state_q == DivFree) && (start_i == DivStart) && !annul_i;
  assign divByZero = (opdata2_i == '0);
  assign lastStep  = (cnt_q == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

`ifdef DIV_SIGNED_EN
  logic negQuo_q, negRem_q;

  // Work on magnitudes; the quotient sign is the XOR of operand signs and the remainder follows the dividend.
  always_comb begin
    dividendMag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    divisorMag  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    finalQuo    = negQuo_q ? -stepQuo : stepQuo;
    finalRem    = negRem_q ? -stepRem : stepRem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
    end else if (accept) begin
      negQuo_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      negRem_q <= signed_div_i && opdata1_i[WIDTH-1];
    end
  end
`else
  logic unused_signedDiv;
  assign unused_signedDiv = signed_div_i;

  always_comb begin
    dividendMag = opdata1_i;
    divisorMag  = opdata2_i;
    finalQuo    = stepQuo;
    finalRem    = stepRem;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DivFree;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DivFree:   if (accept) state_d = divByZero ? DivByZero : DivOn;
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)       state_d = DivFree;
        else if (lastStep) state_d = DivEnd;
      end
      DivEnd:    if (start_i == DivStop) state_d = DivFree;
      default:   state_d = DivFree;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == DivByZero) || (state_q == DivOn);
    ready_o    = ready_q;
    result_o   = result_q;
    div_zero_o = divZero_q;
  end

  // Outputs clear when a divide is accepted so an annulled divide leaves them at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
      divZero_q <= 1'b0;
    end else begin
      ready_q <= (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
      unique case (state_q)
        DivFree: begin
          if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= divByZero ? opdata1_i : dividendMag;
            divisor_q <= divisorMag;
            result_q  <= '0;
            divZero_q <= 1'b0;
          end
        end
        DivByZero: begin
          if (!annul_i) begin
            result_q  <= {quo_q, {WIDTH{1'b1}}};
            divZero_q <= 1'b1;
          end
        end
        DivOn: begin
          if (!annul_i) begin
            rem_q <= stepRem;
            quo_q <= stepQuo;
            cnt_q <= cnt_q + CNT_W'(1);
            if (lastStep) result_q <= {finalRem, finalQuo};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit; expectations for signed vectors follow DIV_SIGNED_EN.
module tb_div_unit;

  localparam int WIDTH = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start_i = 1'b0;
  logic               annul_i = 1'b0;
  logic               signed_div_i = 1'b0;
  logic [WIDTH-1:0]   opdata1_i = '0;
  logic [WIDTH-1:0]   opdata2_i = '0;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o, busy_o, div_zero_o;

  int   vectors = 0;
  int   miscompares = 0;
  logic sawReady;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .div_zero_o   (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic an, input logic sg,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start_i      = st;
    annul_i      = an;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Start a divide and hold start_i; checks latency, result, flag, and that busy drops in END.
  task automatic runDivide(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic sg, input logic [WIDTH-1:0] expQuo, input logic [WIDTH-1:0] expRem,
                           input logic expDz, input int expLat);
    int n;
    applyStimulus(1'b1, 1'b0, sg, a, b);
    tick();
    checkOutput({tag, " busy"}, busy_o, 1);
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, n, expLat);
    checkOutput({tag, " result"}, result_o, {expRem, expQuo});
    checkOutput({tag, " divzero"}, div_zero_o, expDz);
    checkOutput({tag, " busy in END"}, busy_o, 0);
  endtask

  task automatic finishDivide(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput({tag, " ready released"}, ready_o, 0);
  endtask

  initial begin
    $display("[TB] div_unit directed test, signed build = %0d", SignedEn);
    #1;
    checkOutput("reset result", result_o, 0);
    checkOutput("reset ready", ready_o, 0);
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset divzero", div_zero_o, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    runDivide("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
    finishDivide("u100/7");
    runDivide("s-100/7", 32'hFFFFFF9C, 32'd7, 1'b1,
              SignedEn ? 32'hFFFFFFF2 : 32'h24924916, SignedEn ? 32'hFFFFFFFE : 32'd2, 1'b0, 33);
    finishDivide("s-100/7");
    runDivide("u-100/7", 32'hFFFFFF9C, 32'd7, 1'b0, 32'h24924916, 32'd2, 1'b0, 33);
    finishDivide("u-100/7");
    runDivide("s100/-7", 32'd100, 32'hFFFFFFF9, 1'b1,
              SignedEn ? 32'hFFFFFFF2 : 32'd0, SignedEn ? 32'd2 : 32'd100, 1'b0, 33);
    finishDivide("s100/-7");
    runDivide("byzero", 32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2);
    finishDivide("byzero");
    runDivide("overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1,
              SignedEn ? 32'h80000000 : 32'd0, SignedEn ? 32'd0 : 32'h80000000, 1'b0, 33);
    finishDivide("overflow");
    runDivide("umax/1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 33);
    finishDivide("umax/1");
    runDivide("5/9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33);
    finishDivide("5/9");

    // start together with annul in IDLE must be ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5, 32'd1);
    tick();
    tick();
    checkOutput("start+annul idle busy", busy_o, 0);

    // annul after ten iterations
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (10) tick();
    checkOutput("annul pre busy", busy_o, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    tick();
    checkOutput("annul busy", busy_o, 0);
    checkOutput("annul result", result_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    sawReady = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o === 1'b1) sawReady = 1'b1;
    end
    checkOutput("annul no ready", sawReady, 0);
    runDivide("9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);
    finishDivide("9/3");

    // annul while in BYZERO
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    tick();
    checkOutput("annul byzero pre busy", busy_o, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    tick();
    checkOutput("annul byzero busy", busy_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput("annul byzero ready", ready_o, 0);
    checkOutput("annul byzero divzero", div_zero_o, 0);
    checkOutput("annul byzero result", result_o, 0);

    // reset in the middle of ON
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    tick();
    repeat (5) tick();
    checkOutput("midON busy", busy_o, 1);
    rst = 1'b0;
    #1;
    checkOutput("midON reset busy", busy_o, 0);
    checkOutput("midON reset ready", ready_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    tick();

    // held start keeps the result in END, then reset clears it
    runDivide("hold", 32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2);
    repeat (3) tick();
    checkOutput("hold ready", ready_o, 1);
    checkOutput("hold result", result_o, {32'h12345678, 32'hFFFFFFFF});
    rst = 1'b0;
    #1;
    checkOutput("END reset result", result_o, 0);
    checkOutput("END reset ready", ready_o, 0);
    checkOutput("END reset divzero", div_zero_o, 0);
    checkOutput("END reset busy", busy_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
